// File: rtl/sc_velocity_pkg.sv
// Shared definitions for the global-velocity scheduler: FSM encoding and
// sign-magnitude word layout (|S|integer|fraction|).
package sc_velocity_pkg;

   localparam int unsigned N_WIDTH_DEF  = 32;
   localparam int unsigned Q_WIDTH_DEF  = 15;
   localparam int unsigned SIGN_BIT_DEF = N_WIDTH_DEF - 1;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLoad    = 3'd1,
      StStart   = 3'd2,
      StWait    = 3'd3,
      StCapture = 3'd4
   } sc_state_e;

   function automatic int unsigned sm_sign_bit(input int unsigned n_width);
      return n_width - 1;
   endfunction

endpackage

// File: rtl/sc_period_tick.sv
// Free-running period counter: counts 0..PERIOD_CYCLES-1 while enabled and
// emits a one-cycle tick on the wrap cycle; disabled means held at zero.
module sc_period_tick #(
   parameter int unsigned PERIOD_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   output logic tick_o
);

   localparam int unsigned CntWidth = $clog2(PERIOD_CYCLES);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(PERIOD_CYCLES - 1);

   logic [CntWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = enable_i && (cnt_q == CntLast);
      cnt_d  = '0;
      if (enable_i && !tick_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sc_velocity_scheduler.sv
// Periodic launcher for the velocity rotation core: snapshots local samples,
// fires one READY pulse per period, waits for DONE with timeout, latches results.
module sc_velocity_scheduler
   import sc_velocity_pkg::*;
#(
   parameter int unsigned N_WIDTH        = N_WIDTH_DEF,
   parameter int unsigned Q_WIDTH        = Q_WIDTH_DEF,
   parameter int unsigned PERIOD_CYCLES  = 50000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               SC_VELOCITY_SCHEDULER_CLOCK_50,
   input  logic               SC_VELOCITY_SCHEDULER_RESET_InLow,
   input  logic               SC_VELOCITY_SCHEDULER_ENABLE_In,
   input  logic               SC_VELOCITY_SCHEDULER_CLEAR_In,
   input  logic               SC_VELOCITY_SCHEDULER_SAMPLE_VALID_In,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_VX_InBus,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_VY_InBus,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_WZ_InBus,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_THETA_InBus,
   input  logic               SC_VELOCITY_SCHEDULER_CORE_DONE_In,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_VX_InBus,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_VY_InBus,
   input  logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_WZ_InBus,
   output logic               SC_VELOCITY_SCHEDULER_CORE_READY_Out,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_VX_OutBus,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_VY_OutBus,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_WZ_OutBus,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_CORE_THETA_OutBus,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_VX_GLOBAL_OutBus,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_VY_GLOBAL_OutBus,
   output logic [N_WIDTH-1:0] SC_VELOCITY_SCHEDULER_WZ_GLOBAL_OutBus,
   output logic               SC_VELOCITY_SCHEDULER_RESULT_VALID_Out,
   output logic               SC_VELOCITY_SCHEDULER_BUSY_Out,
   output logic               SC_VELOCITY_SCHEDULER_OVERRUN_Out,
   output logic               SC_VELOCITY_SCHEDULER_TIMEOUT_Out
);

   localparam int unsigned TmoWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

   logic clk;
   logic rst_n;
   logic tick;
   logic done_rise;

   assign clk   = SC_VELOCITY_SCHEDULER_CLOCK_50;
   assign rst_n = SC_VELOCITY_SCHEDULER_RESET_InLow;

   sc_state_e           state_q, state_d;
   logic [N_WIDTH-1:0]  snap_vx_q, snap_vx_d, snap_vy_q, snap_vy_d;
   logic [N_WIDTH-1:0]  snap_wz_q, snap_wz_d, snap_th_q, snap_th_d;
   logic [N_WIDTH-1:0]  core_vx_q, core_vx_d, core_vy_q, core_vy_d;
   logic [N_WIDTH-1:0]  core_wz_q, core_wz_d, core_th_q, core_th_d;
   logic [N_WIDTH-1:0]  glob_vx_q, glob_vx_d, glob_vy_q, glob_vy_d, glob_wz_q, glob_wz_d;
   logic                fresh_q, fresh_d;
   logic                done_q, done_d;
   logic [TmoWidth-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                result_valid_q, result_valid_d;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;

   sc_period_tick #(
      .PERIOD_CYCLES(PERIOD_CYCLES)
   ) u_period_tick (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .enable_i(SC_VELOCITY_SCHEDULER_ENABLE_In),
      .tick_o  (tick)
   );

   // A DONE level already high when WAIT is entered is not a rising edge.
   assign done_rise = SC_VELOCITY_SCHEDULER_CORE_DONE_In && !done_q;

   always_comb begin
      state_d        = state_q;
      snap_vx_d      = snap_vx_q;
      snap_vy_d      = snap_vy_q;
      snap_wz_d      = snap_wz_q;
      snap_th_d      = snap_th_q;
      core_vx_d      = core_vx_q;
      core_vy_d      = core_vy_q;
      core_wz_d      = core_wz_q;
      core_th_d      = core_th_q;
      glob_vx_d      = glob_vx_q;
      glob_vy_d      = glob_vy_q;
      glob_wz_d      = glob_wz_q;
      fresh_d        = fresh_q;
      done_d         = SC_VELOCITY_SCHEDULER_CORE_DONE_In;
      tmo_cnt_d      = tmo_cnt_q;
      result_valid_d = 1'b0;
      overrun_d      = overrun_q;
      timeout_d      = timeout_q;

      if (SC_VELOCITY_SCHEDULER_CLEAR_In) begin
         overrun_d = 1'b0;
         timeout_d = 1'b0;
      end

      if (SC_VELOCITY_SCHEDULER_SAMPLE_VALID_In) begin
         snap_vx_d = SC_VELOCITY_SCHEDULER_VX_InBus;
         snap_vy_d = SC_VELOCITY_SCHEDULER_VY_InBus;
         snap_wz_d = SC_VELOCITY_SCHEDULER_WZ_InBus;
         snap_th_d = SC_VELOCITY_SCHEDULER_THETA_InBus;
      end

      unique case (state_q)
         StIdle: begin
            if (tick && fresh_q) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            core_vx_d = snap_vx_q;
            core_vy_d = snap_vy_q;
            core_wz_d = snap_wz_q;
            core_th_d = snap_th_q;
            fresh_d   = 1'b0;
            state_d   = StStart;
         end
         StStart: begin
            tmo_cnt_d = '0;
            state_d   = StWait;
         end
         StWait: begin
            if (done_rise) begin
               state_d = StCapture;
            end else if (tmo_cnt_q == TmoLast) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         StCapture: begin
            glob_vx_d      = SC_VELOCITY_SCHEDULER_CORE_VX_InBus;
            glob_vy_d      = SC_VELOCITY_SCHEDULER_CORE_VY_InBus;
            glob_wz_d      = SC_VELOCITY_SCHEDULER_CORE_WZ_InBus;
            result_valid_d = 1'b1;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Ticks landing on a busy scheduler are dropped, only flagged.
      if (tick && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end
      // A sample coinciding with LOAD survives for the next period.
      if (SC_VELOCITY_SCHEDULER_SAMPLE_VALID_In) begin
         fresh_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         snap_vx_q      <= '0;
         snap_vy_q      <= '0;
         snap_wz_q      <= '0;
         snap_th_q      <= '0;
         core_vx_q      <= '0;
         core_vy_q      <= '0;
         core_wz_q      <= '0;
         core_th_q      <= '0;
         glob_vx_q      <= '0;
         glob_vy_q      <= '0;
         glob_wz_q      <= '0;
         fresh_q        <= 1'b0;
         done_q         <= 1'b0;
         tmo_cnt_q      <= '0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         snap_vx_q      <= snap_vx_d;
         snap_vy_q      <= snap_vy_d;
         snap_wz_q      <= snap_wz_d;
         snap_th_q      <= snap_th_d;
         core_vx_q      <= core_vx_d;
         core_vy_q      <= core_vy_d;
         core_wz_q      <= core_wz_d;
         core_th_q      <= core_th_d;
         glob_vx_q      <= glob_vx_d;
         glob_vy_q      <= glob_vy_d;
         glob_wz_q      <= glob_wz_d;
         fresh_q        <= fresh_d;
         done_q         <= done_d;
         tmo_cnt_q      <= tmo_cnt_d;
         result_valid_q <= result_valid_d;
         overrun_q      <= overrun_d;
         timeout_q      <= timeout_d;
      end
   end

   assign SC_VELOCITY_SCHEDULER_CORE_READY_Out    = (state_q == StStart);
   assign SC_VELOCITY_SCHEDULER_BUSY_Out          = (state_q != StIdle);
   assign SC_VELOCITY_SCHEDULER_CORE_VX_OutBus    = core_vx_q;
   assign SC_VELOCITY_SCHEDULER_CORE_VY_OutBus    = core_vy_q;
   assign SC_VELOCITY_SCHEDULER_CORE_WZ_OutBus    = core_wz_q;
   assign SC_VELOCITY_SCHEDULER_CORE_THETA_OutBus = core_th_q;
   assign SC_VELOCITY_SCHEDULER_VX_GLOBAL_OutBus  = glob_vx_q;
   assign SC_VELOCITY_SCHEDULER_VY_GLOBAL_OutBus  = glob_vy_q;
   assign SC_VELOCITY_SCHEDULER_WZ_GLOBAL_OutBus  = glob_wz_q;
   assign SC_VELOCITY_SCHEDULER_RESULT_VALID_Out  = result_valid_q;
   assign SC_VELOCITY_SCHEDULER_OVERRUN_Out       = overrun_q;
   assign SC_VELOCITY_SCHEDULER_TIMEOUT_Out       = timeout_q;

endmodule
